seg7_scan_decoder: RTL

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_pattern_decode.sv | 21 ++
 rtl/seg7_scan_decoder.sv | 107 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment codes, digit-enable codes and scan FSM states shared by the seven-segment scan decoder.
package seg7_pkg;

    typedef enum logic {WAIT, HELD} scan_state_t;

    // Active-low a..g patterns, indexed by BCD value
    localparam logic [6:0] SEG_CODES [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    localparam logic [3:0] DIG_ONES      = 4'b1110;
    localparam logic [3:0] DIG_TENS      = 4'b1101;
    localparam logic [3:0] DIG_HUNDREDS  = 4'b1011;
    localparam logic [3:0] DIG_THOUSANDS = 4'b0111;
    localparam logic [3:0] DIG_BLANK     = 4'b1111;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: maps an active-low 7-segment pattern to its BCD value and flags non-digit patterns.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] bcd,
    output logic       legal
);

    always_comb begin
        bcd   = '0;
        legal = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (pattern == SEG_CODES[i]) begin
                bcd   = 4'(i);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers four BCD digits from a multiplexed, active-low seven-segment bus
// by capturing each {segments, digit enable} combination once it has been stable long enough.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [6:0] seg_in,
    input  logic [3:0] digit_in,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic [3:0] thousands,
    output logic [3:0] digit_valid,
    output logic       frame_done,
    output logic       pattern_err
);

    localparam logic [15:0] LAST = 16'(STABLE_CYCLES - 1);

    logic [6:0]       seg_s1, seg_s2, seg_d;
    logic [3:0]       dig_s1, dig_s2, dig_d;
    logic [15:0]      cnt;
    scan_state_t      state, state_nx;
    logic [3:0]       seen, seen_nx, sel;
    logic [3:0][3:0]  val;
    logic [3:0]       bcd;
    logic             legal, same, cap, one_hot, good, err, frame;

    seg7_pattern_decode u_decode (
        .pattern (seg_d),
        .bcd     (bcd),
        .legal   (legal)
    );

    assign same    = {seg_s2, dig_s2} == {seg_d, dig_d};
    assign one_hot = dig_d inside {DIG_ONES, DIG_TENS, DIG_HUNDREDS, DIG_THOUSANDS};
    assign sel     = ~dig_d;
    assign seen_nx = seen | sel;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state <= WAIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            WAIT: state_nx = (cnt == LAST && same) ? HELD : WAIT;
            HELD: state_nx = same ? HELD : WAIT;
            default: state_nx = WAIT;
        endcase
    end

    // The capture samples the delayed copy, which equals the live value whenever same is true
    always_comb begin
        cap   = state == WAIT && cnt == LAST && same;
        good  = cap && one_hot && legal;
        err   = cap && dig_d != DIG_BLANK && !(one_hot && legal);
        frame = good && seen_nx == 4'hf;
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            seg_s1      <= '0;
            seg_s2      <= '0;
            seg_d       <= '0;
            dig_s1      <= '0;
            dig_s2      <= '0;
            dig_d       <= '0;
            cnt         <= '0;
            seen        <= '0;
            val         <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
            pattern_err <= 1'b0;
        end else begin
            seg_s1      <= seg_in;
            seg_s2      <= seg_s1;
            seg_d       <= seg_s2;
            dig_s1      <= digit_in;
            dig_s2      <= dig_s1;
            dig_d       <= dig_s2;
            cnt         <= !same ? '0 : (cnt == '1 ? cnt : cnt + 16'd1);
            frame_done  <= frame;
            pattern_err <= err;
            if (good) begin
                seen        <= frame ? '0 : seen_nx;
                digit_valid <= digit_valid | sel;
                for (int i = 0; i < 4; i++) begin
                    if (sel[i]) val[i] <= bcd;
                end
            end
        end
    end

    assign ones      = val[0];
    assign tens      = val[1];
    assign hundreds  = val[2];
    assign thousands = val[3];

endmodule
